uart_in_buffer: RTL and testbench

- Parametrised receive buffer between the UART receiver and the core's `in`/`fin` instruction path.
- Replaces the fixed 4096-byte, unbounded-index, receiver_valid-clocked buffer with a single-clock circular FIFO. It has full/empty tracking and sticky overflow.
- Adds a stall-friendly pop handshake that returns either one byte (zero-extended) or one 32-bit word packed from four bytes, so `fin` can load a whole float in one instruction.

---
 rtl/uart_in_buffer.sv | 119 +++++++++++
 tb/tb_uart_in_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_in_buffer.sv
// ---------------------------------------------------------------------------
// uart_in_buffer
// Single-clock circular receive FIFO that sits between the UART receiver and
// the core's in/fin path. Bytes come in on receiver_valid rising edges. The
// core pops either one zero-extended byte or one packed 32-bit word.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   r_data           received byte, valid while receiver_valid is high
//   receiver_valid   byte-valid level; one push per high period
//   pop_req          pop request, held until pop_ack
//   pop_word         0 = pop 1 byte, 1 = pop 4 bytes
//   pop_ack          one-cycle pulse; pop_data is valid
//   pop_data         popped value, held until the next pop
//   count            bytes stored, 0..DEPTH
//   empty, full      count == 0 / count == DEPTH
//   overflow         sticky: a byte was dropped because the FIFO was full
//   clear_ovf        synchronous clear of overflow
// ---------------------------------------------------------------------------
module uart_in_buffer #(
   parameter int DEPTH      = 4096,
   parameter int ADDR_W     = 12,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        r_data,
   input  logic              receiver_valid,
   input  logic              pop_req,
   input  logic              pop_word,
   output logic              pop_ack,
   output logic [31:0]       pop_data,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   input  logic              clear_ovf
);

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              rv_d;

   logic              push;
   logic              push_ok;
   logic              fire;
   logic [ADDR_W:0]   need;
   logic [ADDR_W:0]   count_nx;
   logic [7:0]        b0, b1, b2, b3;
   logic [31:0]       word_val;

   // Push edge detect, pop fire decision, next count and word packing.
   always_comb begin
      push     = receiver_valid & ~rv_d;
      // full is the registered pre-cycle value, so a pop completing this
      // cycle does not make room for a simultaneous push.
      push_ok  = push & ~full;
      need     = pop_word ? (ADDR_W+1)'(4) : (ADDR_W+1)'(1);
      // ~pop_ack forbids back-to-back pops and makes a held request count
      // as new from the cycle after its ack.
      fire     = pop_req & ~pop_ack & (count >= need);
      count_nx = count + (ADDR_W+1)'(push_ok)
                       - (fire ? need : {(ADDR_W+1){1'b0}});
      b0 = mem[rd_ptr];
      b1 = mem[rd_ptr + ADDR_W'(1)];
      b2 = mem[rd_ptr + ADDR_W'(2)];
      b3 = mem[rd_ptr + ADDR_W'(3)];
      if (BIG_ENDIAN) begin
         word_val = {b0, b1, b2, b3};
      end else begin
         word_val = {b3, b2, b1, b0};
      end
   end

   // Byte storage; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= r_data;
      end
   end

   // Pointers, occupancy flags, pop response and sticky overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= {ADDR_W{1'b0}};
         rd_ptr   <= {ADDR_W{1'b0}};
         rv_d     <= 1'b0;
         count    <= {(ADDR_W+1){1'b0}};
         empty    <= 1'b1;
         full     <= 1'b0;
         pop_ack  <= 1'b0;
         pop_data <= 32'd0;
         overflow <= 1'b0;
      end else begin
         rv_d <= receiver_valid;
         if (push_ok) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (fire) begin
            rd_ptr   <= rd_ptr + (pop_word ? ADDR_W'(4) : ADDR_W'(1));
            pop_data <= pop_word ? word_val : {24'd0, b0};
         end
         pop_ack <= fire;
         count   <= count_nx;
         empty   <= (count_nx == {(ADDR_W+1){1'b0}});
         full    <= (count_nx == DEPTH_C);
         // A drop in the same cycle as clear_ovf keeps the flag set.
         if (push & full) begin
            overflow <= 1'b1;
         end else if (clear_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_in_buffer.sv
// ---------------------------------------------------------------------------
// tb_uart_in_buffer
// Directed bench for uart_in_buffer. Two DEPTH=8 instances, one big-endian
// and one little-endian, share all inputs so that word packing can be
// compared for identical traffic. Inputs are driven and outputs sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_in_buffer;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  r_data;
   logic        receiver_valid;
   logic        pop_req;
   logic        pop_word;
   logic        clear_ovf;

   logic        ack_a, ack_b;
   logic [31:0] data_a, data_b;
   logic [3:0]  count_a, count_b;
   logic        empty_a, empty_b;
   logic        full_a, full_b;
   logic        ovf_a, ovf_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] da, db;
   int          lat;
   logic        acked;

   always #5 clk = ~clk;

   uart_in_buffer #(.DEPTH(8), .ADDR_W(3), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .rstn(rstn), .r_data(r_data), .receiver_valid(receiver_valid),
      .pop_req(pop_req), .pop_word(pop_word), .pop_ack(ack_a), .pop_data(data_a),
      .count(count_a), .empty(empty_a), .full(full_a), .overflow(ovf_a),
      .clear_ovf(clear_ovf)
   );

   uart_in_buffer #(.DEPTH(8), .ADDR_W(3), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .rstn(rstn), .r_data(r_data), .receiver_valid(receiver_valid),
      .pop_req(pop_req), .pop_word(pop_word), .pop_ack(ack_b), .pop_data(data_b),
      .count(count_b), .empty(empty_b), .full(full_b), .overflow(ovf_b),
      .clear_ovf(clear_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Holds receiver_valid high for three cycles; called and returns at a negedge.
   task automatic push_byte(input logic [7:0] b);
      r_data         = b;
      receiver_valid = 1'b1;
      repeat (3) @(negedge clk);
      receiver_valid = 1'b0;
      @(negedge clk);
   endtask

   // Issues a pop and waits (bounded) for the ack; lat = cycles to ack, 0 on timeout.
   task automatic pop(input logic w, output logic [31:0] oa, output logic [31:0] ob,
                      output int olat);
      pop_word = w;
      pop_req  = 1'b1;
      olat     = 0;
      oa       = 32'd0;
      ob       = 32'd0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (ack_a) begin
            olat = i;
            oa   = data_a;
            ob   = data_b;
            break;
         end
      end
      pop_req = 1'b0;
   endtask

   initial begin
      rstn           = 1'b0;
      r_data         = 8'h00;
      receiver_valid = 1'b0;
      pop_req        = 1'b0;
      pop_word       = 1'b0;
      clear_ovf      = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_count",    32'(count_a), 32'd0);
      check("rst_empty",    32'(empty_a), 32'd1);
      check("rst_full",     32'(full_a),  32'd0);
      check("rst_overflow", 32'(ovf_a),   32'd0);
      check("rst_ack",      32'(ack_a),   32'd0);
      check("rst_data",     data_a,       32'd0);

      // Three bytes, each with receiver_valid held 3 cycles, then byte pops
      push_byte(8'h41);
      push_byte(8'h42);
      push_byte(8'h43);
      check("push3_count", 32'(count_a), 32'd3);
      pop(1'b0, da, db, lat);
      check("byte_pop_latency", 32'(lat), 32'd1);
      check("byte_pop_data",    da,       32'h0000_0041);
      check("byte_pop_count",   32'(count_a), 32'd2);
      @(negedge clk);
      check("ack_one_cycle",    32'(ack_a), 32'd0);
      pop(1'b0, da, db, lat);
      check("byte_pop2_data",   da, 32'h0000_0042);
      pop(1'b0, da, db, lat);
      check("byte_pop3_data",   da, 32'h0000_0043);
      check("drain_empty",      32'(empty_a), 32'd1);

      // Word pop of a float, both packings
      push_byte(8'h3F);
      push_byte(8'h80);
      push_byte(8'h00);
      push_byte(8'h00);
      pop(1'b1, da, db, lat);
      check("word_latency",  32'(lat), 32'd1);
      check("word_be",       da, 32'h3F80_0000);
      check("word_le",       db, 32'h0000_803F);
      check("word_count",    32'(count_a), 32'd0);
      check("word_empty",    32'(empty_a), 32'd1);

      // Word pop stalls with only two bytes stored (also wraps mem[7] -> mem[2])
      push_byte(8'h11);
      push_byte(8'h22);
      pop_word = 1'b1;
      pop_req  = 1'b1;
      acked    = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ack_a) acked = 1'b1;
      end
      check("stall_no_ack", 32'(acked),   32'd0);
      check("stall_count",  32'(count_a), 32'd2);
      push_byte(8'h33);
      check("stall_3_no_ack", 32'(ack_a), 32'd0);
      r_data         = 8'h44;
      receiver_valid = 1'b1;
      @(negedge clk);
      check("stall_4th_stored", 32'(count_a), 32'd4);
      check("stall_4th_no_ack", 32'(ack_a),   32'd0);
      @(negedge clk);
      check("stall_ack",      32'(ack_a), 32'd1);
      check("stall_data_be",  data_a, 32'h1122_3344);
      check("stall_data_le",  data_b, 32'h4433_2211);
      check("stall_count0",   32'(count_a), 32'd0);
      pop_req = 1'b0;
      @(negedge clk);
      receiver_valid = 1'b0;
      @(negedge clk);

      // Fill to full, drop the ninth byte, drain in order, clear overflow
      for (int i = 1; i <= 9; i++) begin
         push_byte(8'(i));
         if (i == 8) begin
            check("fill8_full",  32'(full_a),  32'd1);
            check("fill8_count", 32'(count_a), 32'd8);
            check("fill8_ovf",   32'(ovf_a),   32'd0);
         end
      end
      check("fill9_count", 32'(count_a), 32'd8);
      check("fill9_ovf",   32'(ovf_a),   32'd1);
      for (int i = 1; i <= 8; i++) begin
         pop(1'b0, da, db, lat);
         check("drain_order", da, 32'(i));
      end
      check("drain8_empty",   32'(empty_a), 32'd1);
      check("ovf_sticky",     32'(ovf_a),   32'd1);
      clear_ovf = 1'b1;
      @(negedge clk);
      clear_ovf = 1'b0;
      check("ovf_cleared",    32'(ovf_a),   32'd0);

      // Move pointers to 6, then a word spanning mem[6],mem[7],mem[0],mem[1]
      push_byte(8'h51);
      push_byte(8'h52);
      push_byte(8'h53);
      for (int i = 1; i <= 3; i++) begin
         pop(1'b0, da, db, lat);
         check("pre_wrap_data", da, 32'h50 + 32'(i));
      end
      push_byte(8'hA0);
      push_byte(8'hA1);
      push_byte(8'hA2);
      push_byte(8'hA3);
      pop(1'b1, da, db, lat);
      check("wrap_be", da, 32'hA0A1_A2A3);
      check("wrap_le", db, 32'hA3A2_A1A0);

      // Push edge coinciding with a byte pop fire at count=5
      for (int i = 1; i <= 5; i++) push_byte(8'h60 + 8'(i));
      check("pre_sim_count", 32'(count_a), 32'd5);
      r_data         = 8'h66;
      receiver_valid = 1'b1;
      pop_word       = 1'b0;
      pop_req        = 1'b1;
      @(negedge clk);
      check("sim_ack",   32'(ack_a),   32'd1);
      check("sim_data",  data_a,       32'h0000_0061);
      check("sim_count", 32'(count_a), 32'd5);
      pop_req = 1'b0;
      repeat (2) @(negedge clk);
      receiver_valid = 1'b0;
      @(negedge clk);
      check("sim_count_hold", 32'(count_a), 32'd5);

      // Set overflow, leave 3 bytes, then reset during a pending word pop
      pop(1'b1, da, db, lat);
      check("pre_rst_word", da, 32'h6263_6465);
      for (int i = 0; i < 8; i++) push_byte(8'h70 + 8'(i));
      check("pre_rst_ovf", 32'(ovf_a), 32'd1);
      pop(1'b1, da, db, lat);
      pop(1'b0, da, db, lat);
      check("pre_rst_count", 32'(count_a), 32'd3);
      pop_word = 1'b1;
      pop_req  = 1'b1;
      repeat (3) @(negedge clk);
      check("wait_no_ack", 32'(ack_a), 32'd0);
      #1 rstn = 1'b0;
      #1;
      check("async_rst_count", 32'(count_a), 32'd0);
      check("async_rst_ack",   32'(ack_a),   32'd0);
      check("async_rst_ovf",   32'(ovf_a),   32'd0);
      check("async_rst_empty", 32'(empty_a), 32'd1);
      check("async_rst_data",  data_a,       32'd0);
      pop_req = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_ack",   32'(ack_a),   32'd0);
      check("post_rst_count", 32'(count_a), 32'd0);
      check("post_rst_le_count", 32'(count_b), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
